// File: rtl/modular_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : modular_addsub_pipe
//  Description : Two-stage pipelined modular add/subtract, c = (a +/- b) mod Q,
//                with valid/ready flow control and a pass-through tag.
//                Optional operand range flag: MODADDSUB_RANGE_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module modular_addsub_pipe #(
    parameter int              WIDTH = 30,
    parameter longint unsigned Q     = 64'd1063321601,
    parameter int              TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_c,
    output logic [TAG_W-1:0]  out_tag
`ifdef MODADDSUB_RANGE_CHECK_EN
    ,
    output logic              out_err
`endif
);

    localparam logic [WIDTH-1:0] c_q_lo  = WIDTH'(Q);
    localparam logic [WIDTH:0]   c_q_ext = (WIDTH+1)'(Q);

    logic             w_adv;
    logic [WIDTH:0]   w_raw;
    logic [WIDTH-1:0] w_raw_lo;
    logic [WIDTH-1:0] w_plus_q;
    logic [WIDTH-1:0] w_minus_q;
    logic [WIDTH-1:0] w_fixed;

    logic             r_s1_valid;
    logic             r_s1_op;
    logic [WIDTH:0]   r_s1_raw;
    logic [TAG_W-1:0] r_s1_tag;

    // The whole pipe moves as one; a full output register blocks both stages.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_raw = in_op ? ({1'b0, in_a} - {1'b0, in_b})
                         : ({1'b0, in_a} + {1'b0, in_b});

    // Correction only ever needs the low WIDTH bits, so wrap in WIDTH-bit arithmetic.
    assign w_raw_lo  = r_s1_raw[WIDTH-1:0];
    assign w_plus_q  = w_raw_lo + c_q_lo;
    assign w_minus_q = w_raw_lo - c_q_lo;

    always_comb begin
        w_fixed = w_raw_lo;
        if (r_s1_op) begin
            if (r_s1_raw[WIDTH]) begin
                w_fixed = w_plus_q;
            end
        end else if (r_s1_raw >= c_q_ext) begin
            w_fixed = w_minus_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_tag   <= '0;
            out_valid  <= 1'b0;
            out_c      <= '0;
            out_tag    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= in_op;
            r_s1_raw   <= w_raw;
            r_s1_tag   <= in_tag;
            out_valid  <= r_s1_valid;
            out_c      <= w_fixed;
            out_tag    <= r_s1_tag;
        end
    end

`ifdef MODADDSUB_RANGE_CHECK_EN
    logic r_s1_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_err <= 1'b0;
            out_err  <= 1'b0;
        end else if (w_adv) begin
            r_s1_err <= (in_a >= c_q_lo) || (in_b >= c_q_lo);
            out_err  <= r_s1_err;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/modular_addsub_pipe.md
Name: modular_addsub_pipe

Overview:
- Pipelined modular add/subtract unit: c = (a + b) mod Q or (a - b) mod Q, operation selected per transaction.
- Generalises the fixed 30-bit, 2-cycle modular subtractor to:
  - parametrised width and modulus;
  - runtime add/sub select;
  - valid/ready flow control with backpressure;
  - a sideband tag carried alongside the data.
- Sits in the NTT butterfly datapath, feeding and draining butterfly operands while address/index tags travel with the data.

Parameters:
- WIDTH, 30: operand/result width in bits.
- Q, 1063321601: modulus. Required: 2 < Q < 2^WIDTH. Bench checks this at elaboration.
- TAG_W, 8: width of the pass-through tag; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_op  in  1  0 = add, 1 = subtract.
- in_a  in  WIDTH  operand a, 0 <= a < Q.
- in_b  in  WIDTH  operand b, 0 <= b < Q.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_c  out  WIDTH  result, 0 <= c < Q.
- out_tag  out  TAG_W  tag of this result.
- out_err  out  1  only present with MODADDSUB_RANGE_CHECK_EN.

Behaviour:
- Reset:
  - s1_valid = 0, out_valid = 0, out_c = 0, out_tag = 0, out_err = 0.
  - Reset overrides all other activity in that cycle, including mid-operation. In-flight transactions are discarded and not reported.
- Pipeline advance: adv = !out_valid | out_ready. Both stages load only when adv = 1; when adv = 0 both hold every register.
- in_ready = adv, a combinational function of out_valid/out_ready only. A transfer occurs when in_valid & in_ready.
- Stage 1, on adv:
  - s1_valid <= in_valid.
  - s1_raw is WIDTH+1 bits: in_a + in_b when in_op = 0, otherwise two's-complement in_a - in_b.
  - s1_op <= in_op; s1_tag <= in_tag.
  - Data registers may load regardless of in_valid.
- Stage 2, on adv:
  - out_valid <= s1_valid; out_tag <= s1_tag.
  - Subtract: if s1_raw[WIDTH] = 1 (negative), out_c <= s1_raw + Q (low WIDTH bits); else out_c <= s1_raw.
  - Add: if s1_raw >= Q (unsigned, WIDTH+1 bits), out_c <= s1_raw - Q; else out_c <= s1_raw.
- Latency and throughput:
  - Latency is exactly 2 cycles from the accepted transfer to out_valid when out_ready is held high.
  - Throughput is 1 result per cycle.
- Ordering: results leave in acceptance order. No loss and no duplication under any out_ready pattern.
- Bubbles: an accepted cycle with in_valid = 0 propagates as out_valid = 0. Bubbles collapse while out_valid = 0 because adv = 1.
- Output stability: while out_valid = 1 and out_ready = 0, out_c, out_tag and out_err are stable.
- Boundaries:
  - add (Q-1)+(Q-1) = 2Q-2 fits in WIDTH+1 bits, giving Q-2.
  - sub 0-(Q-1) gives 1.
  - a = b gives 0 for sub.
- Operands >= Q are out of contract. Without the optional feature the result is the same formula applied to those operands, unspecified but deterministic.

Optional Feature:
- Macro: MODADDSUB_RANGE_CHECK_EN.
- When defined:
  - Stage 1 registers s1_err = (in_a >= Q) | (in_b >= Q).
  - Stage 2 forwards it to out_err, aligned with out_c and held under stall.
  - The result is still computed and the transaction still completes.
- When undefined: out_err port and all related logic are absent.

Test Plan:
- Q=1063321601, out_ready=1; sub a=5,b=7, tag=0x11 -> 2 cycles later out_valid=1, out_c=1063321599, out_tag=0x11.
- add a=1063321600,b=1063321600 -> out_c=1063321599; add a=3,b=4 -> 7; sub a=9,b=9 -> 0; sub a=0,b=1063321600 -> 1.
- Stream of 6 back-to-back mixed ops (tags 0..5) with out_ready low for cycles 3-5:
  - in_ready=0 whenever out_valid=1 & out_ready=0;
  - all 6 results appear in tag order with the correct values;
  - outputs are stable during the stall.
- in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid shows 1,0,1,0 delayed 2 cycles; no spurious results.
- rst asserted for 1 cycle with 2 transactions in flight -> next cycle out_valid=0, out_c=0, out_tag=0; the dropped transactions never appear; the next accepted op completes normally 2 cycles later.
- With MODADDSUB_RANGE_CHECK_EN: add a=1063321601,b=0 -> out_err=1 with its result; a=1,b=2 -> out_err=0. Without the macro, port out_err does not exist (compile check).
